// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and sizing for the EX-stage multiply/divide sequencer.
// Op and state encodings, divide iteration count and op decode helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;

    // A zero divisor always fits, so its quotient fills with ones and the dividend lands in rem.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        fits_s    = (shifted_s >= {1'b0, divisor});
        diff_s    = shifted_s[WIDTH-1:0] - divisor;
        if (fits_s) begin
            rem_next = diff_s;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: stalls EX while the op runs, writes HI/LO once.
// Optional MULDIV_DIV0_EARLY_EN short-circuits a zero divisor at accept.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             stallreq_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    md_state_e          state_r;
    md_state_e          state_s;
    logic [CNT_W-1:0]   count_r;
    logic               sgn_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept_s;
    logic               load_mul_s;
    logic               step_s;
    logic               fix_s;
    logic               div0_s;
    logic               stall_s;

    logic               in_sgn_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic               mul_sgn_s;
    logic [WIDTH-1:0]   mul_a_s;
    logic [WIDTH-1:0]   mul_b_s;
    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               a_neg_s;
    logic               q_neg_s;
    logic [WIDTH-1:0]   rem_nx_s;
    logic [WIDTH-1:0]   quo_nx_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_nx_s),
        .quo_next (quo_nx_s)
    );

    // Operand conditioning; multiply reads live operands in IDLE so MUL_CYCLES==1 still works.
    always_comb begin
        in_sgn_s = op_is_signed(op_i);
        if (in_sgn_s & src_a_i[WIDTH-1]) begin
            abs_a_s = negate(src_a_i);
        end else begin
            abs_a_s = src_a_i;
        end
        if (in_sgn_s & src_b_i[WIDTH-1]) begin
            abs_b_s = negate(src_b_i);
        end else begin
            abs_b_s = src_b_i;
        end
        if (state_r == S_IDLE) begin
            mul_a_s   = src_a_i;
            mul_b_s   = src_b_i;
            mul_sgn_s = in_sgn_s;
        end else begin
            mul_a_s   = a_r;
            mul_b_s   = b_r;
            mul_sgn_s = sgn_r;
        end
        ext_a_s = {{WIDTH{mul_sgn_s & mul_a_s[WIDTH-1]}}, mul_a_s};
        ext_b_s = {{WIDTH{mul_sgn_s & mul_b_s[WIDTH-1]}}, mul_b_s};
        prod_s  = ext_a_s * ext_b_s;
        a_neg_s = sgn_r & a_r[WIDTH-1];
        q_neg_s = a_neg_s ^ (sgn_r & b_r[WIDTH-1]);
    end

    // Next-state and control strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        load_mul_s = 1'b0;
        step_s     = 1'b0;
        fix_s      = 1'b0;
        div0_s     = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    accept_s = 1'b1;
                    stall_s  = 1'b1;
                    if (op_is_div(op_i)) begin
`ifdef MULDIV_DIV0_EARLY_EN
                        if (src_b_i == {WIDTH{1'b0}}) begin
                            div0_s  = 1'b1;
                            state_s = S_DONE;
                        end else begin
                            state_s = S_DIV;
                        end
`else
                        state_s = S_DIV;
`endif
                    end else if (MUL_CYCLES == 1) begin
                        load_mul_s = 1'b1;
                        state_s    = S_DONE;
                    end else begin
                        state_s = S_MUL;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                stall_s = 1'b1;
                if (count_r == MUL_LAST) begin
                    load_mul_s = 1'b1;
                    state_s    = S_DONE;
                end else begin
                    state_s = S_MUL;
                end
            end
            S_DIV: begin
                stall_s = 1'b1;
                step_s  = 1'b1;
                if (count_r == DIV_LAST) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_DIV;
                end
            end
            S_FIX: begin
                stall_s = 1'b1;
                fix_s   = 1'b1;
                state_s = S_DONE;
            end
            // The instruction is still visible in EX here, so start_i is ignored.
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register and shared multiply/divide cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                count_r <= op_is_div(op_i) ? {CNT_W{1'b0}} : CNT_W'(1);
            end else if ((state_r == S_MUL) || step_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Latched operands and divider working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_r <= 1'b0;
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            sgn_r <= in_sgn_s;
            a_r   <= src_a_i;
            b_r   <= src_b_i;
            rem_r <= {WIDTH{1'b0}};
            quo_r <= abs_a_s;
            dvs_r <= abs_b_s;
        end else if (step_s) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
        end else begin
            rem_r <= rem_r;
            quo_r <= quo_r;
        end
    end

    // Result registers: loaded on entry to DONE and held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (load_mul_s) begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
        end else if (fix_s) begin
            hi_r <= a_neg_s ? negate(rem_r) : rem_r;
            lo_r <= q_neg_s ? negate(quo_r) : quo_r;
        end else if (div0_s) begin
            hi_r <= src_a_i;
            lo_r <= {WIDTH{1'b1}};
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign stallreq_o = stall_s;
    assign hilo_we_o  = (state_r == S_DONE);
    assign busy_o     = (state_r != S_IDLE);
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

endmodule
